// File: rtl/blockmem_copy.sv
// Word-move engine between operand blockmems: copies a run of words from a
// registered-read source port to a destination write port, or fills a range.
module blockmem_copy #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  ready,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] src_read_addr,
  input  logic [DATA_WIDTH-1:0] src_read_data,
  output logic                  dst_wr,
  output logic [ADDR_WIDTH-1:0] dst_write_addr,
  output logic [DATA_WIDTH-1:0] dst_write_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t                r_state;
  logic                  r_mode;
  logic [DATA_WIDTH-1:0] r_fill;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_src_addr;
  logic [ADDR_WIDTH-1:0] r_dst_next;
  logic                  r_drain;
  logic                  r_rd_pending;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_dst_wr;
  logic [ADDR_WIDTH-1:0] r_dst_addr;
  logic [DATA_WIDTH-1:0] r_dst_data;

  logic                  w_launch;

  assign w_launch = start & r_ready;

  // Read issued in cycle k returns in k+1 and is written in k+2; r_rd_pending
  // marks the cycle in which the source data bus holds a wanted word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_mode       <= 1'b0;
      r_fill       <= '0;
      r_count      <= '0;
      r_src_addr   <= '0;
      r_dst_next   <= '0;
      r_drain      <= 1'b0;
      r_rd_pending <= 1'b0;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_dst_wr     <= 1'b0;
      r_dst_addr   <= '0;
      r_dst_data   <= '0;
    end else begin
      r_rd_pending <= (r_state == READ);
      r_dst_wr     <= r_rd_pending;
      if (r_rd_pending) begin
        r_dst_addr <= r_dst_next;
        r_dst_next <= r_dst_next + 1'b1;
        r_dst_data <= r_mode ? r_fill : src_read_data;
      end

      case (r_state)
        IDLE, DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          if (w_launch) begin
            r_mode     <= mode;
            r_fill     <= fill_value;
            r_src_addr <= src_base;
            r_dst_next <= dst_base;
            r_count    <= length;
            if (length == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= READ;
              r_ready <= 1'b0;
            end
          end
        end
        READ: begin
          r_src_addr <= r_src_addr + 1'b1;
          r_count    <= r_count - 1'b1;
          if (r_count == 1) begin
            r_state <= DRAIN;
            r_drain <= 1'b1;
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_drain <= 1'b0;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready          = r_ready;
  assign done           = r_done;
  assign src_read_addr  = r_src_addr;
  assign dst_wr         = r_dst_wr;
  assign dst_write_addr = r_dst_addr;
  assign dst_write_data = r_dst_data;

endmodule

// File: tb/tb_blockmem_copy.sv
// Directed bench for blockmem_copy: a registered-read source memory model
// feeds the engine and every cycle of each operation is checked.
module tb_blockmem_copy;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [7:0]  src_base;
  logic [7:0]  dst_base;
  logic [7:0]  length;
  logic [31:0] fill_value;
  logic        ready;
  logic        done;
  logic [7:0]  src_read_addr;
  logic [31:0] src_read_data;
  logic        dst_wr;
  logic [7:0]  dst_write_addr;
  logic [31:0] dst_write_data;

  logic [31:0] srcMem [256];

  int nCompared;
  int nMismatched;

  blockmem_copy dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .mode           (mode),
    .src_base       (src_base),
    .dst_base       (dst_base),
    .length         (length),
    .fill_value     (fill_value),
    .ready          (ready),
    .done           (done),
    .src_read_addr  (src_read_addr),
    .src_read_data  (src_read_data),
    .dst_wr         (dst_wr),
    .dst_write_addr (dst_write_addr),
    .dst_write_data (dst_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source blockmem with a one-cycle registered read port.
  always @(posedge clk) src_read_data <= srcMem[src_read_addr];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Launches one operation and checks every cycle up to n+5 after the start edge.
  task automatic applyStimulus(input logic m, input logic [7:0] s, input logic [7:0] d,
                               input logic [7:0] n, input logic [31:0] f,
                               input int pulseAt);
    int         nWrites;
    int         nDone;
    int         doneCycle;
    logic       expWr;
    logic [7:0] expAddr;
    logic [7:0] expSrc;
    logic [31:0] expData;
    @(negedge clk);
    mode = m; src_base = s; dst_base = d; length = n; fill_value = f; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~m; src_base = 8'h5A; dst_base = 8'hA5; length = 8'd17; fill_value = 32'h1234_5678;
    nWrites = 0;
    nDone = 0;
    doneCycle = (n == 0) ? 1 : n + 3;
    for (int k = 1; k <= n + 5; k++) begin
      @(negedge clk);
      expWr = (n != 0) && (k >= 3) && (k <= n + 2);
      checkOutput($sformatf("dst_wr c%0d", k), dst_wr, expWr);
      checkOutput($sformatf("done c%0d", k), done, k == doneCycle);
      checkOutput($sformatf("ready c%0d", k), ready, k >= doneCycle);
      if (k <= n) begin
        expSrc = s + 8'(k - 1);
        checkOutput($sformatf("src_addr c%0d", k), src_read_addr, expSrc);
      end
      if (expWr) begin
        expAddr = d + 8'(k - 3);
        expSrc  = s + 8'(k - 3);
        expData = m ? f : srcMem[expSrc];
        checkOutput($sformatf("wr_addr c%0d", k), dst_write_addr, expAddr);
        checkOutput($sformatf("wr_data c%0d", k), dst_write_data, expData);
      end
      if (dst_wr) nWrites++;
      if (done) nDone++;
      if (k == pulseAt) start = 1'b1;
      if (k == pulseAt + 1) start = 1'b0;
    end
    checkOutput("write count", nWrites, n);
    checkOutput("done count", nDone, 1);
  endtask

  initial begin
    int nStray;
    nCompared   = 0;
    nMismatched = 0;
    reset_n = 1'b0; start = 1'b0; mode = 1'b0;
    src_base = '0; dst_base = '0; length = '0; fill_value = '0;
    for (int i = 0; i < 256; i++) srcMem[i] = 32'hC0DE_0000 | i;
    srcMem[8'h10] = 32'hA0A0_A0A0;
    srcMem[8'h11] = 32'hA1A1_A1A1;
    srcMem[8'h12] = 32'hA2A2_A2A2;
    srcMem[8'h13] = 32'hA3A3_A3A3;

    repeat (3) @(negedge clk);
    checkOutput("reset ready", ready, 1'b1);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset dst_wr", dst_wr, 1'b0);
    checkOutput("reset src_addr", src_read_addr, 8'h00);
    checkOutput("reset wr_addr", dst_write_addr, 8'h00);
    checkOutput("reset wr_data", dst_write_data, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] copy 4 words 0x10 -> 0x40");
    applyStimulus(1'b0, 8'h10, 8'h40, 8'd4, 32'h0, 0);
    $display("[TB] fill 255 words at 0x80");
    applyStimulus(1'b1, 8'h00, 8'h80, 8'd255, 32'hDEAD_BEEF, 0);
    $display("[TB] zero length");
    applyStimulus(1'b0, 8'h22, 8'h33, 8'd0, 32'h0, 0);
    $display("[TB] wrapped copy 0xFF -> 0xFE");
    applyStimulus(1'b0, 8'hFF, 8'hFE, 8'd3, 32'h0, 0);
    $display("[TB] start pulsed while busy");
    applyStimulus(1'b0, 8'h30, 8'h90, 8'd5, 32'h0, 2);
    $display("[TB] same-base rewrite");
    applyStimulus(1'b0, 8'h70, 8'h70, 8'd2, 32'h0, 0);

    $display("[TB] reset during 8-word copy");
    @(negedge clk);
    mode = 1'b0; src_base = 8'h20; dst_base = 8'h60; length = 8'd8; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre-abort dst_wr", dst_wr, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort dst_wr", dst_wr, 1'b0);
    checkOutput("abort ready", ready, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    nStray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dst_wr || done) nStray++;
    end
    checkOutput("post-abort activity", nStray, 0);
    checkOutput("post-abort ready", ready, 1'b1);
    applyStimulus(1'b0, 8'h20, 8'h60, 8'd6, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
